// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz raster generator: pixel-rate strobe, h/v counters, and a
// single output register that keeps hsync, vsync and rgb aligned on the pins.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,   // system clocks per pixel, must be >= 2
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        video_on,
  output logic        pixel_tick,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_in_hsync;
  logic             w_in_vsync;

  assign pixel_tick  = (r_div == DIV_LAST);
  assign w_h_last    = (h_count == H_LAST);
  assign w_v_last    = (v_count == V_LAST);
  assign video_on    = (h_count < H_VIS) && (v_count < V_VIS);
  assign frame_start = pixel_tick && w_h_last && w_v_last;
  assign w_in_hsync  = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
  assign w_in_vsync  = (v_count >= VS_FIRST) && (v_count <= VS_LAST);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge counts; blocking here would let hsync see the
  // already-incremented h_count and skew it against rgb_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (pixel_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pixel_tick) begin
      if (w_h_last) begin
        h_count <= '0;
        v_count <= w_v_last ? 10'd0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  // Pin register: one pixel behind the counts, identical for all three.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb_out <= '0;
    end else if (pixel_tick) begin
      hsync   <= ~w_in_hsync;
      vsync   <= ~w_in_vsync;
      rgb_out <= video_on ? rgb_in : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a shrunken raster (15x8 pixels,
// CLK_DIV=4) so whole frames, wraps and sync windows fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int CLK_DIV = 4;
  localparam int H_TOTAL = 15;   // 8 + 2 + 3 + 2
  localparam int V_TOTAL = 8;    // 4 + 1 + 2 + 1
  localparam int FRAME   = H_TOTAL * V_TOTAL;

  typedef struct {
    int         h;
    int         v;
    logic       von;
    logic       fs;
    logic       hs;
    logic       vs;
    logic [11:0] rgb;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pat_mode;
  logic [11:0] rgb_in;
  logic [9:0]  h_count, v_count;
  logic        video_on, pixel_tick, frame_start, hsync, vsync;
  logic [11:0] rgb_out;

  exp_t sb_q[$];
  int   n_checks, n_errors;
  int   edges;
  int   hs_low, vs_low, fs_cnt;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV),
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
    .h_count(h_count), .v_count(v_count), .video_on(video_on),
    .pixel_tick(pixel_tick), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out)
  );

  // Pixel source: either solid white or a position-coded pattern.
  assign rgb_in = pat_mode ? {4'hA, h_count[3:0], v_count[3:0]} : 12'hFFF;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] pattern(input int h, input int v, input logic mode);
    return mode ? {4'hA, 4'(h), 4'(v)} : 12'hFFF;
  endfunction

  // Expected view during the n-th tick after reset: counts at position n,
  // pin outputs from position n-1 (reset values for n == 0).
  // Hand-derived windows: hsync low for h in [10,12], vsync low for v in [5,6].
  function automatic exp_t model(input int n, input logic mode);
    exp_t e;
    int   p, q, hq, vq;
    p     = n % FRAME;
    e.h   = p % H_TOTAL;
    e.v   = p / H_TOTAL;
    e.von = (e.h < 8) && (e.v < 4);
    e.fs  = (p == FRAME - 1);
    if (n == 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = 12'h000;
    end else begin
      q     = (n - 1) % FRAME;
      hq    = q % H_TOTAL;
      vq    = q / H_TOTAL;
      e.hs  = !(hq >= 10 && hq <= 12);
      e.vs  = !(vq >= 5 && vq <= 6);
      e.rgb = (hq < 8 && vq < 4) ? pattern(hq, vq, mode) : 12'h000;
    end
    return e;
  endfunction

  task automatic push_ticks(input int count, input logic mode);
    for (int n = 0; n < count; n++) sb_q.push_back(model(n, mode));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, int'(done), 1);
    if (!done) sb_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_h"},     int'(h_count),     0);
    check({tag, "_v"},     int'(v_count),     0);
    check({tag, "_hsync"}, int'(hsync),       1);
    check({tag, "_vsync"}, int'(vsync),       1);
    check({tag, "_rgb"},   int'(rgb_out),     0);
    check({tag, "_tick"},  int'(pixel_tick),  0);
    check({tag, "_fs"},    int'(frame_start), 0);
    check({tag, "_von"},   int'(video_on),    1);
  endtask

  initial begin : edge_counter
    forever begin
      @(posedge clk);
      if (!rst_n) edges = 0;
      else        edges++;
    end
  end

  initial begin : monitor
    exp_t        e;
    logic        first, prev_tick, prev_hs, prev_vs;
    logic [9:0]  prev_h, prev_v;
    logic [11:0] prev_rgb;
    first = 1'b1; prev_tick = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
    prev_h = '0; prev_v = '0; prev_rgb = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        first = 1'b1; prev_tick = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
        prev_h = '0; prev_v = '0; prev_rgb = '0;
      end else begin
        if (pixel_tick) begin
          check("tick_spacing", edges, first ? CLK_DIV - 1 : CLK_DIV);
          edges = 0;
          first = 1'b0;
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("h_count",     int'(h_count),     e.h);
            check("v_count",     int'(v_count),     e.v);
            check("video_on",    int'(video_on),    int'(e.von));
            check("frame_start", int'(frame_start), int'(e.fs));
            check("hsync",       int'(hsync),       int'(e.hs));
            check("vsync",       int'(vsync),       int'(e.vs));
            check("rgb_out",     int'(rgb_out),     int'(e.rgb));
            if (!hsync)     hs_low++;
            if (!vsync)     vs_low++;
            if (frame_start) fs_cnt++;
          end
        end else begin
          check("frame_start_idle", int'(frame_start), 0);
          if (!prev_tick) begin
            check("hold_counts", int'({h_count, v_count}), int'({prev_h, prev_v}));
            check("hold_pins", int'({hsync, vsync, rgb_out}), int'({prev_hs, prev_vs, prev_rgb}));
          end
        end
        prev_tick = pixel_tick; prev_h = h_count; prev_v = v_count;
        prev_hs = hsync; prev_vs = vsync; prev_rgb = rgb_out;
      end
    end
  end

  initial begin : stimulus
    n_checks = 0; n_errors = 0; edges = 0;
    hs_low = 0; vs_low = 0; fs_cnt = 0;
    pat_mode = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Power-on reset for 5 clocks, released mid low phase.
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state("por");
    push_ticks(2 * FRAME + 1, 1'b0);
    rst_n = 1'b1;

    // Two full frames of white: every tick scored, then whole-frame totals.
    wait_drain("drain_frames", 4 * (2 * FRAME + 1) + 50);
    check("hsync_low_ticks", hs_low, 48);   // 2 frames * 8 lines * 3
    check("vsync_low_ticks", vs_low, 60);   // 2 frames * 2 lines * 15
    check("frame_start_count", fs_cnt, 2);

    // Restart with the position-coded pattern, run into line 2.
    pat_mode = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_a");
    @(negedge clk);
    #1;
    push_ticks(2 * H_TOTAL + 6, 1'b1);      // last scored tick sits at (5,2)
    rst_n = 1'b1;
    wait_drain("drain_line", 4 * (2 * H_TOTAL + 6) + 50);

    // Mid-line reset while the tick at (5,2) is still pending.
    check("pre_reset_h", int'(h_count), 5);
    check("pre_reset_v", int'(v_count), 2);
    check("pre_reset_rgb", int'(rgb_out), int'(12'hA42));
    rst_n = 1'b0;
    #1;
    check_reset_state("midline");
    @(negedge clk);
    #1;
    push_ticks(H_TOTAL + 6, 1'b1);
    rst_n = 1'b1;
    wait_drain("drain_restart", 4 * (H_TOTAL + 6) + 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster that every pixel-source block in the display path consumes: h_count/v_count and a pixel-rate strobe for 640x480@60 Hz.
- Takes back the merged 12-bit pixel colour from those sources and drives the VGA connector.
- Registers hsync, vsync and rgb together so all three stay aligned with the counts that produced them.
- Sits between the 100 MHz system clock domain and the VGA pins.

Parameters:
- CLK_DIV, 4: system clocks per pixel; must be >= 2.
- H_VISIBLE, 640: active pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- rgb_in  in  12  pixel colour for the current h_count/v_count, combinational from the pixel sources
- h_count  out  10  current column, 0..H_TOTAL-1
- v_count  out  10  current line, 0..V_TOTAL-1
- video_on  out  1  high when h_count < H_VISIBLE and v_count < V_VISIBLE (combinational on the counters)
- pixel_tick  out  1  one-clk strobe; the counters advance on this cycle
- frame_start  out  1  one-clk strobe when the counters wrap to (0,0)
- hsync  out  1  registered, active low
- vsync  out  1  registered, active low
- rgb_out  out  12  registered pixel colour, forced to 0 during blanking

Behaviour:
- Derived constants: H_TOTAL = sum of the H parameters (800 by default); V_TOTAL = sum of the V parameters (525 by default).
- Reset (asynchronous, rst_n low):
  - div counter = 0, h_count = 0, v_count = 0.
  - hsync = 1, vsync = 1, rgb_out = 0.
  - pixel_tick = 0, frame_start = 0.
  - video_on therefore reads 1 during reset.
- Divider:
  - counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is high for exactly the clk cycle in which div == CLK_DIV-1.
  - After rst_n deasserts, the first pixel_tick is on the CLK_DIV-th clk.
- Counters (update only on pixel_tick edges):
  - If h_count == H_TOTAL-1: h_count <= 0.
    - If v_count == V_TOTAL-1 then v_count <= 0, else v_count + 1.
  - Otherwise h_count + 1; v_count holds.
  - Neither counter ever leaves its range. No saturation path exists.
- frame_start: combinational, equal to pixel_tick AND h_count == H_TOTAL-1 AND v_count == V_TOTAL-1. It fires once per H_TOTAL*V_TOTAL ticks.
- Output register (loads only on pixel_tick edges, sampling the pre-increment counts):
  - hsync <= ~(h_count in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1]), i.e. [656,751] by default.
  - vsync <= ~(v_count in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1]), i.e. [490,491] by default.
  - rgb_out <= video_on ? rgb_in : 12'h000.
- Latency: pin outputs lag h_count/v_count by exactly one pixel period, identically for hsync, vsync and rgb_out. There is no relative skew between the three.
- rgb_in is sampled once per pixel on the tick edge. It only has to be stable by the end of the tick cycle; it is ignored at all other times.
- Mid-operation reset: everything returns to reset values asynchronously. On release, timing restarts at (0,0) with the full CLK_DIV wait before the first tick. No partial frame state is kept.

Test Plan:
- Reset: rst_n=0 for 5 clks, checked mid-divider -> h=0, v=0, hsync=vsync=1, rgb_out=0, pixel_tick=0. After release, pixel_tick first seen on clk 4 and then every 4 clks.
- Line wrap: run to h=799, v=10 -> next tick gives h=0, v=11. At h=799, v=524 -> next tick gives (0,0), and frame_start is high only on that one tick cycle. frame_start count = 1 per 420000 ticks.
- hsync window: measure one line -> hsync low for exactly 96 consecutive ticks. First low sample follows the tick where h=656. High again after the tick where h=752.
- vsync window: measure one frame -> vsync low for exactly 2 lines (1600 ticks). Low begins after the tick at h=0, v=490.
- Blanking and alignment: hold rgb_in=12'hFFF -> rgb_out=FFF after ticks with h<640, v<480. rgb_out=000 after ticks at h>=640 or v>=480. rgb_out changes on the same edge as hsync.
- Mid-line reset: assert rst_n=0 at h=300, v=200 for 1 clk -> immediate return to reset values. Restart from (0,0) with a 4-clk first-tick delay.
